// File: rtl/seq_divider.sv
// Sequential 32-bit signed/unsigned divider: one restoring radix-2 step per cycle,
// followed by a single sign-fixup cycle. done is high only while idle.
module seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  div_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [63:0] result,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SIGNED   = 2'b10;
    localparam logic [1:0] OP_UNSIGNED = 2'b01;

    state_t      state_reg;
    logic [5:0]  cnt_reg;
    logic [32:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] dvsr_reg;
    logic [31:0] dvnd_reg;
    logic        sign_q_reg;
    logic        sign_r_reg;
    logic [63:0] result_reg;
    logic        done_reg;

    logic        accept;
    logic        is_signed;
    logic [31:0] dvnd_mag;
    logic [31:0] dvsr_mag;
    logic [33:0] trial;
    logic        trial_neg;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic        dvsr_zero;

    assign accept    = (div_op == OP_SIGNED) || (div_op == OP_UNSIGNED);
    assign is_signed = (div_op == OP_SIGNED);

    // Operand magnitudes are only meaningful on the accept edge.
    assign dvnd_mag = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign dvsr_mag = (is_signed && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    // Trial subtract on a widened copy so the borrow lands in the top bit.
    always_comb begin
        trial     = {rem_reg, quo_reg[31]} - {2'b00, dvsr_reg};
        trial_neg = trial[33];
        rem_next  = trial_neg ? {rem_reg[31:0], quo_reg[31]} : trial[32:0];
        quo_next  = {quo_reg[30:0], ~trial_neg};
    end

    assign quo_fix   = sign_q_reg ? (~quo_reg + 32'd1) : quo_reg;
    assign rem_fix   = sign_r_reg ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];
    assign dvsr_zero = (dvsr_reg == 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 6'd0;
            rem_reg    <= 33'd0;
            quo_reg    <= 32'd0;
            dvsr_reg   <= 32'd0;
            dvnd_reg   <= 32'd0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            result_reg <= 64'd0;
            done_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dvnd_reg   <= dividend;
                        dvsr_reg   <= dvsr_mag;
                        quo_reg    <= dvnd_mag;
                        rem_reg    <= 33'd0;
                        cnt_reg    <= 6'd0;
                        sign_q_reg <= is_signed & (dividend[31] ^ divisor[31]);
                        sign_r_reg <= is_signed & dividend[31];
                        done_reg   <= 1'b0;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'd31) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero bypasses sign correction and reports the raw dividend.
                    if (dvsr_zero) begin
                        result_reg <= {dvnd_reg, 32'hFFFF_FFFF};
                    end else begin
                        result_reg <= {rem_fix, quo_fix};
                    end
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign result = result_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and corner-value checks of seq_divider: latency, results, reset abort,
// ignored inputs while busy, and back-to-back operation.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [63:0] result;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_divider dut (
        .clk      (clk),
        .rst      (rst),
        .div_op   (div_op),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        int     ia, ib;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
            ia = a;
            ib = b;
            sa = ia;
            sb = ib;
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    // Accepts on the next edge, keeps the inputs asserted while busy (they must be
    // ignored), optionally scrambles them at cycle perturb, then checks latency/result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int perturb);
        logic [63:0] prev;
        int n;
        prev = result;
        @(negedge clk);
        div_op   = op;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        check({tag, ".done_low"}, {63'd0, done}, 64'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == perturb) begin
                div_op   = 2'b10;
                dividend = 32'h0000_0005;
                divisor  = 32'h0000_0003;
            end
            if (n == 16) check({tag, ".hold"}, result, prev);
        end while (!done && n < 40);
        div_op = 2'b00;
        check({tag, ".latency"}, 64'(n), 64'd33);
        check({tag, ".result"}, result, exp);
        $display("[TB] %s op=%b %h / %h -> %h (exp %h) cycles=%0d", tag, op, a, b, result, exp, n);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] hold;
        logic [1:0]  op;
        logic [31:0] a, b;
        int          low_seen;

        rst      = 1'b1;
        div_op   = 2'b01;
        dividend = 32'd9;
        divisor  = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("reset.done", {63'd0, done}, 64'd1);
        check("reset.result", result, 64'd0);
        $display("[TB] reset done=%b result=%h", done, result);

        // No-op commands leave the block idle.
        @(negedge clk);
        rst    = 1'b0;
        div_op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("noop00.done", {63'd0, done}, 64'd1);
        div_op = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        check("noop11.done", {63'd0, done}, 64'd1);
        check("noop11.result", result, 64'd0);
        $display("[TB] noop done=%b result=%h", done, result);
        div_op = 2'b00;

        run_op("u100_7",   2'b01, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 0);
        run_op("s-7_2",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("s_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0);
        run_op("u5_0",     2'b01, 32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 0);
        run_op("s7_-2",    2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);
        run_op("s-7_-2",   2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 0);
        run_op("uff_1",    2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("s-1_1",    2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 0);
        run_op("u0_5",     2'b01, 32'h0000_0000, 32'h0000_0005, 64'h0000_0000_0000_0000, 0);
        run_op("s-5_0",    2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 64'hFFFF_FFFB_FFFF_FFFF, 0);
        run_op("u8m_ff",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 0);
        run_op("s8m_2",    2'b10, 32'h8000_0000, 32'h0000_0002, 64'h0000_0000_C000_0000, 0);
        run_op("u1000_33", 2'b01, 32'h0000_03E8, 32'h0000_0021, 64'h0000_000A_0000_001E, 0);
        run_op("perturb",  2'b01, 32'hFFFF_FFFF, 32'h0000_0010, 64'h0000_000F_0FFF_FFFF, 5);

        // Reset at cycle 10 aborts the operation without a completion edge.
        hold = result;
        @(negedge clk);
        div_op   = 2'b01;
        dividend = 32'hFFFF_FFFF;
        divisor  = 32'h0000_0010;
        @(posedge clk);
        #1;
        check("abort.accept", {63'd0, done}, 64'd0);
        check("abort.hold", result, hold);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.done", {63'd0, done}, 64'd1);
        check("abort.result", result, 64'd0);
        @(negedge clk);
        rst    = 1'b0;
        div_op = 2'b00;
        low_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (!done) low_seen++;
        end
        check("abort.no_restart", 64'(low_seen), 64'd0);
        check("abort.result_kept", result, 64'd0);
        $display("[TB] abort done=%b result=%h low_cycles=%0d", done, result, low_seen);

        // Reset ignores a valid command; the first edge after it accepts one.
        @(negedge clk);
        rst    = 1'b1;
        div_op = 2'b01;
        @(posedge clk);
        #1;
        check("rst_ignores_op", {63'd0, done}, 64'd1);
        rst    = 1'b0;
        div_op = 2'b00;
        run_op("post_rst", 2'b01, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 0);

        // Back-to-back corner-heavy mix against the reference function.
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            a  = pick_val();
            b  = pick_val();
            run_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
